// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Start/ready/valid handshake; a result is produced WIDTH cycles after the accepting edge.
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN; without it i_signed
// is ignored and no sign/negate logic is built.
module seq_multiplier #(
    parameter int unsigned WIDTH = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_var1,
    input  logic [WIDTH-1:0]   i_var2,
    input  logic               i_signed,
    output logic               o_ready,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_mult
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mult_q, mult_d;

    logic [WIDTH-1:0]   var1_mag, var2_mag;
    logic [2*WIDTH-1:0] addend, acc_sum, result;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;
    logic neg1, neg2;

    // Convert operands to magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        neg1     = i_signed & i_var1[WIDTH-1];
        neg2     = i_signed & i_var2[WIDTH-1];
        var1_mag = neg1 ? -i_var1 : i_var1;
        var2_mag = neg2 ? -i_var2 : i_var2;
        result   = neg_q ? -acc_sum : acc_sum;
    end
`else
    logic unused_signed;
    assign unused_signed = i_signed;

    // Unsigned-only build: operands pass straight through.
    always_comb begin
        var1_mag = i_var1;
        var2_mag = i_var2;
        result   = acc_sum;
    end
`endif

    // One shift-add step: add the multiplicand weighted by the current bit position.
    always_comb begin
        addend  = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        acc_sum = acc_q + (mplier_q[0] ? addend : '0);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mult_d   = mult_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StBusy;
                    mcand_d  = var1_mag;
                    mplier_d = var2_mag;
                    cnt_d    = '0;
                    acc_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d    = neg1 ^ neg2;
`endif
                end
            end
            StBusy: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    mult_d  = result;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mult_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mult_q   <= mult_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_mult  = mult_q;

endmodule
